// File: rtl/vfpm_operand_loader.sv
// rtl/vfpm_operand_loader.sv - streams A/B operand vectors into the FP multiplier register file
// Writes VEC_LEN A words then VEC_LEN B words, starts the multiplier and reports completion.
module vfpm_operand_loader #(
  parameter int DATA_W  = 32,
  parameter int VEC_LEN = 32,
  parameter int ADDR_W  = 7,
  parameter int A_BASE  = 0,
  parameter int B_BASE  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              mult_start,
  input  logic              mult_done,
  output logic              busy,
  output logic              load_done
);

  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(VEC_LEN - 1);
  localparam logic [ADDR_W-1:0] A_ADDR   = ADDR_W'(A_BASE);
  localparam logic [ADDR_W-1:0] B_ADDR   = ADDR_W'(B_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_FLUSH,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              xfer;
  logic              last;
  logic [ADDR_W-1:0] base;

  // in_ready is only ever high in LOAD_A/LOAD_B, so xfer implies a load state
  assign xfer = in_valid && in_ready;
  assign last = (cnt == CNT_LAST);
  assign base = (state == S_LOAD_B) ? B_ADDR : A_ADDR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      in_ready   <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      mult_start <= 1'b0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      rf_we      <= 1'b0;
      mult_start <= 1'b0;
      load_done  <= 1'b0;

      if (xfer) begin
        rf_we    <= 1'b1;
        rf_waddr <= base + ADDR_W'(cnt);
        rf_wdata <= in_data;
        cnt      <= last ? '0 : cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (go) begin
            state    <= S_LOAD_A;
            cnt      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_LOAD_A: begin
          if (xfer && last) begin
            state <= S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (xfer && last) begin
            state    <= S_FLUSH;
            in_ready <= 1'b0;
          end
        end
        // last B write is committed while in FLUSH, before start is seen
        S_FLUSH: begin
          state      <= S_START;
          mult_start <= 1'b1;
        end
        S_START: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mult_done) begin
            state     <= S_DONE;
            load_done <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vfpm_operand_loader.sv
// tb/tb_vfpm_operand_loader.sv - directed self-checking bench for vfpm_operand_loader
module tb_vfpm_operand_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        mult_done = 1'b0;
  logic        in_ready;
  logic        rf_we;
  logic [6:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mult_start;
  logic        busy;
  logic        load_done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int          hs_q[$];
  int          we_q[$];
  int          ms_q[$];
  int          ld_q[$];
  logic [6:0]  wa_q[$];
  logic [31:0] wd_q[$];

  always #5 clk = ~clk;

  vfpm_operand_loader dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .mult_start (mult_start),
    .mult_done  (mult_done),
    .busy       (busy),
    .load_done  (load_done)
  );

  // Event log sampled mid-cycle; a handshake logged at cycle c transfers at the next edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (in_valid && in_ready) hs_q.push_back(cyc);
    if (rf_we) begin
      we_q.push_back(cyc);
      wa_q.push_back(rf_waddr);
      wd_q.push_back(rf_wdata);
    end
    if (mult_start) ms_q.push_back(cyc);
    if (load_done) ld_q.push_back(cyc);
  end

  task automatic clear_logs();
    hs_q.delete(); we_q.delete(); ms_q.delete(); ld_q.delete();
    wa_q.delete(); wd_q.delete();
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic feed(input bit gappy, input logic [31:0] base_val, input int n, output bit ok);
    int k = 0;
    int t = 0;
    int h0 = hs_q.size();
    while ((hs_q.size() - h0) < n && t < 1000) begin
      in_valid = gappy ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      in_data  = base_val + 32'(hs_q.size() - h0);
      @(posedge clk); #1;
      k++;
      t++;
    end
    in_valid = 1'b0;
    ok = ((hs_q.size() - h0) == n);
  endtask

  task automatic finish_op(input int lat, output bit ok);
    int t = 0;
    while (ms_q.size() == 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (lat) begin
      @(posedge clk); #1;
    end
    mult_done = 1'b1;
    @(posedge clk); #1;
    mult_done = 1'b0;
    t = 0;
    while (ld_q.size() == 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    ok = (ms_q.size() != 0) && (ld_q.size() != 0);
  endtask

  task automatic test_reset();
    bit ok;
    repeat (3) @(negedge clk);
    vectors++;
    if ({in_ready, rf_we, rf_waddr, rf_wdata, mult_start, busy, load_done} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got rdy=%b we=%b a=%0h d=%0h st=%b busy=%b ld=%b want all 0",
               in_ready, rf_we, rf_waddr, rf_wdata, mult_start, busy, load_done);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_go got rdy=%b busy=%b want 0 0", in_ready, busy);
    end
    @(posedge clk); #1;
    pulse_go();
    feed(1'b0, 32'h3F800000, 3, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL reset_feed_timeout got ok=%b want 1", ok);
    end
    #1;
    reset = 1'b1;
    #1;
    vectors++;
    if ({in_ready, rf_we, rf_waddr, rf_wdata, mult_start, busy, load_done} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got rdy=%b we=%b a=%0h d=%0h st=%b busy=%b ld=%b want all 0",
               in_ready, rf_we, rf_waddr, rf_wdata, mult_start, busy, load_done);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_streaming();
    bit ok;
    clear_logs();
    pulse_go();
    feed(1'b0, 32'h3F800000, 64, ok);
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    vectors++;
    if (!ok || hs_q.size() != 64) begin
      miscompares++;
      $display("FAIL stream_handshakes got %0d want 64", hs_q.size());
    end
    vectors++;
    if (wa_q.size() != 64) begin
      miscompares++;
      $display("FAIL stream_write_count got %0d want 64", wa_q.size());
    end else begin
      for (int i = 0; i < 64; i++) begin
        vectors++;
        if (wa_q[i] !== 7'(i) || wd_q[i] !== 32'h3F800000 + 32'(i) || we_q[i] !== we_q[0] + i) begin
          miscompares++;
          $display("FAIL stream_write[%0d] got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                   i, wa_q[i], wd_q[i], we_q[i], i, 32'h3F800000 + 32'(i), we_q[0] + i);
        end
      end
      vectors++;
      if (ms_q.size() != 1 || ms_q[0] != hs_q[63] + 2) begin
        miscompares++;
        $display("FAIL stream_mult_start got n=%0d at=%0d want n=1 at=%0d",
                 ms_q.size(), (ms_q.size() > 0) ? ms_q[0] : -1, hs_q[63] + 2);
      end
    end
    finish_op(0, ok);
    vectors++;
    if (!ok || ld_q.size() != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_complete got ok=%b ld=%0d busy=%b want 1 1 0", ok, ld_q.size(), busy);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit ok2;
    clear_logs();
    pulse_go();
    feed(1'b1, 32'hC0000000, 64, ok);
    finish_op(3, ok2);
    vectors++;
    if (!ok || !ok2 || wa_q.size() != 64 || hs_q.size() != 64) begin
      miscompares++;
      $display("FAIL bp_counts got hs=%0d wr=%0d ok=%b%b want 64 64 11", hs_q.size(), wa_q.size(), ok, ok2);
    end else begin
      for (int i = 0; i < 64; i++) begin
        vectors++;
        if (wa_q[i] !== 7'(i) || wd_q[i] !== 32'hC0000000 + 32'(i) || we_q[i] !== hs_q[i] + 1) begin
          miscompares++;
          $display("FAIL bp_write[%0d] got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                   i, wa_q[i], wd_q[i], we_q[i], i, 32'hC0000000 + 32'(i), hs_q[i] + 1);
        end
      end
    end
    vectors++;
    if (ms_q.size() != 1 || ld_q.size() != 1) begin
      miscompares++;
      $display("FAIL bp_pulses got st=%0d ld=%0d want 1 1", ms_q.size(), ld_q.size());
    end
  endtask

  task automatic test_stale_done();
    bit ok;
    int t = 0;
    clear_logs();
    mult_done = 1'b1;
    pulse_go();
    fork
      feed(1'b0, 32'h40000000, 64, ok);
      begin
        repeat (5) @(posedge clk);
        #1;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
      end
    join
    while (ld_q.size() == 0 && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    vectors++;
    if (!ok || wa_q.size() != 64 || ms_q.size() != 1 || ld_q.size() != 1) begin
      miscompares++;
      $display("FAIL stale_counts got wr=%0d st=%0d ld=%0d want 64 1 1", wa_q.size(), ms_q.size(), ld_q.size());
    end else begin
      for (int i = 0; i < 64; i++) begin
        vectors++;
        if (wa_q[i] !== 7'(i) || wd_q[i] !== 32'h40000000 + 32'(i)) begin
          miscompares++;
          $display("FAIL stale_write[%0d] got a=%0d d=%h want a=%0d d=%h",
                   i, wa_q[i], wd_q[i], i, 32'h40000000 + 32'(i));
        end
      end
      vectors++;
      if (ms_q[0] != hs_q[63] + 2 || ld_q[0] != ms_q[0] + 2) begin
        miscompares++;
        $display("FAIL stale_timing got st=%0d ld=%0d want st=%0d ld=%0d",
                 ms_q[0], ld_q[0], hs_q[63] + 2, hs_q[63] + 4);
      end
    end
    @(negedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || load_done !== 1'b0) begin
      miscompares++;
      $display("FAIL stale_after_done got busy=%b ld=%b want 0 0", busy, load_done);
    end
    mult_done = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    bit ok2;
    clear_logs();
    pulse_go();
    feed(1'b0, 32'h41000000, 41, ok);
    reset = 1'b1;
    #1;
    vectors++;
    if (rf_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midload_reset got we=%b busy=%b rdy=%b want 0 0 0", rf_we, busy, in_ready);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (!ok || ms_q.size() != 0 || wa_q.size() != 40 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midload_abort got st=%0d wr=%0d busy=%b want 0 40 0", ms_q.size(), wa_q.size(), busy);
    end
    clear_logs();
    pulse_go();
    feed(1'b0, 32'h42000000, 64, ok);
    finish_op(2, ok2);
    vectors++;
    if (!ok || !ok2 || wa_q.size() != 64) begin
      miscompares++;
      $display("FAIL reload_count got wr=%0d ok=%b%b want 64 11", wa_q.size(), ok, ok2);
    end else begin
      for (int i = 0; i < 64; i++) begin
        vectors++;
        if (wa_q[i] !== 7'(i) || wd_q[i] !== 32'h42000000 + 32'(i)) begin
          miscompares++;
          $display("FAIL reload_write[%0d] got a=%0d d=%h want a=%0d d=%h",
                   i, wa_q[i], wd_q[i], i, 32'h42000000 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit ok2;
    int t = 0;
    clear_logs();
    pulse_go();
    feed(1'b0, 32'h3E000000, 64, ok);
    mult_done = 1'b1;
    while (ld_q.size() == 0 && t < 100) begin
      @(negedge clk); #1;
      t++;
    end
    mult_done = 1'b0;
    vectors++;
    if (!ok || ld_q.size() != 1) begin
      miscompares++;
      $display("FAIL b2b_first_op got ld=%0d ok=%b want 1 1", ld_q.size(), ok);
    end
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_go_in_done got busy=%b rdy=%b want 0 0", busy, in_ready);
    end
    clear_logs();
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    vectors++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second_go got busy=%b rdy=%b want 1 1", busy, in_ready);
    end
    feed(1'b0, 32'h3D000000, 64, ok);
    finish_op(1, ok2);
    vectors++;
    if (!ok || !ok2 || wa_q.size() != 64 || ms_q.size() != 1 || ld_q.size() != 1) begin
      miscompares++;
      $display("FAIL b2b_second_op got wr=%0d st=%0d ld=%0d want 64 1 1", wa_q.size(), ms_q.size(), ld_q.size());
    end else begin
      for (int i = 0; i < 64; i++) begin
        vectors++;
        if (wa_q[i] !== 7'(i) || wd_q[i] !== 32'h3D000000 + 32'(i)) begin
          miscompares++;
          $display("FAIL b2b_write[%0d] got a=%0d d=%h want a=%0d d=%h",
                   i, wa_q[i], wd_q[i], i, 32'h3D000000 + 32'(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_stale_done();
    test_reset_mid_load();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
